// File: rtl/gru_fpu_pkg.sv
// Shared definitions for the GRU FPU front-end blocks: sequencer state
// encoding, common float constants and the default float word width.
package gru_fpu_pkg;

  localparam int FPU_DATA_WIDTH = 32;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_MUL,
    ST_MUL_WAIT,
    ST_ADD,
    ST_ADD_WAIT,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/gru_dot_sequencer_if.sv
// Shared FPU pair bus: common a/b operand bus, start/done handshakes for the
// multiplier and the adder, and their result words.
interface gru_dot_sequencer_if
  import gru_fpu_pkg::*;
#(
  parameter int DATA_WIDTH = FPU_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] fpu_a;
  logic [DATA_WIDTH-1:0] fpu_b;
  logic                  mult_start;
  logic                  add_start;
  logic                  mult_done;
  logic                  add_done;
  logic [DATA_WIDTH-1:0] mult_out;
  logic [DATA_WIDTH-1:0] add_out;

  // Sequencer side: drives operands and start pulses
  modport master (
    output fpu_a, fpu_b, mult_start, add_start,
    input  mult_done, add_done, mult_out, add_out
  );

  // FPU side: consumes operands, returns results
  modport slave (
    input  fpu_a, fpu_b, mult_start, add_start,
    output mult_done, add_done, mult_out, add_out
  );
endinterface

// File: rtl/gru_dot_watchdog.sv
// FPU done watchdog: counts cycles spent waiting on the FPU and flags the
// last permitted waiting cycle. Cleared in the cycle before each wait starts.
module gru_dot_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Count waiting cycles; restart from zero on every new wait
  always_ff @(posedge clk) begin
    if (rstn || i_clear) r_cnt <= '0;
    else if (i_run)      r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = i_run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/gru_dot_sequencer.sv
// GRU gate pre-activation sequencer: acc = bias + sum(w[i]*x[i]) computed by
// time-sharing an external FPU multiplier/adder pair.
// Optional FPU watchdog enabled by defining GRU_DOT_SEQ_TIMEOUT_EN.
module gru_dot_sequencer
  import gru_fpu_pkg::*;
#(
  parameter int DATA_WIDTH     = FPU_DATA_WIDTH,
  parameter int VEC_LEN        = 16,
  parameter int ADDR_WIDTH     = $clog2(VEC_LEN),
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_elems,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [ADDR_WIDTH-1:0] elem_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] x_data,
  gru_dot_sequencer_if.master   fpu,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
);
  localparam int NW = ADDR_WIDTH + 1;

  seq_state_t            r_state;
  logic [NW-1:0]         r_n;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_fpu_a;
  logic [DATA_WIDTH-1:0] r_fpu_b;
  logic                  r_mult_start;
  logic                  r_add_start;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_result;

  logic [NW-1:0]         w_n_sat;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic                  w_wd_expired;

  assign w_n_sat    = (n_elems > NW'(VEC_LEN)) ? NW'(VEC_LEN) : n_elems;
  assign w_last     = ({1'b0, r_idx} == (r_n - NW'(1)));
  assign w_idx_next = r_idx + ADDR_WIDTH'(1);

`ifdef GRU_DOT_SEQ_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_run;
  assign w_wd_clear = (r_state == ST_MUL) || (r_state == ST_ADD);
  assign w_wd_run   = (r_state == ST_MUL_WAIT) || (r_state == ST_ADD_WAIT);

  gru_dot_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rstn     (rstn),
    .i_clear  (w_wd_clear),
    .i_run    (w_wd_run),
    .o_expired(w_wd_expired)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_wd_expired = 1'b0;
`endif

  // Control FSM; every output is a register set on the transition into the
  // state that owns it, so start/done pulses line up with their states.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state      <= ST_IDLE;
      r_n          <= '0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_fpu_a      <= FP_ZERO;
      r_fpu_b      <= FP_ZERO;
      r_mult_start <= 1'b0;
      r_add_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_result     <= FP_ZERO;
    end else begin
      r_mult_start <= 1'b0;
      r_add_start  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n    <= w_n_sat;
            r_acc  <= bias;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (w_n_sat != '0) begin
              r_addr  <= '0;
              r_state <= ST_FETCH;
            end else begin
              r_result <= bias;
              r_done   <= 1'b1;
              r_state  <= ST_FINISH;
            end
          end
        end
        ST_FETCH:   r_state <= ST_WAIT_RD;
        ST_WAIT_RD: begin
          // Memory data is valid now; it becomes the multiplier operands
          r_fpu_a      <= w_data;
          r_fpu_b      <= x_data;
          r_mult_start <= 1'b1;
          r_state      <= ST_MUL;
        end
        ST_MUL:     r_state <= ST_MUL_WAIT;
        ST_MUL_WAIT: begin
          if (fpu.mult_done) begin
            r_fpu_a     <= r_acc;
            r_fpu_b     <= fpu.mult_out;
            r_add_start <= 1'b1;
            r_state     <= ST_ADD;
          end else if (w_wd_expired) begin
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_ADD:     r_state <= ST_ADD_WAIT;
        ST_ADD_WAIT: begin
          if (fpu.add_done) begin
            r_acc <= fpu.add_out;
            if (w_last) begin
              r_result <= fpu.add_out;
              r_done   <= 1'b1;
              r_state  <= ST_FINISH;
            end else begin
              r_idx   <= w_idx_next;
              r_addr  <= w_idx_next;
              r_state <= ST_FETCH;
            end
          end else if (w_wd_expired) begin
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign elem_addr      = r_addr;
  assign fpu.fpu_a      = r_fpu_a;
  assign fpu.fpu_b      = r_fpu_b;
  assign fpu.mult_start = r_mult_start;
  assign fpu.add_start  = r_add_start;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign result         = r_result;
endmodule

// File: doc/gru_dot_sequencer.md
# gru_dot_sequencer

Sequencer that computes one GRU gate pre-activation, acc = bias + Σ w[i]·x[i], in IEEE-754 single precision by time-sharing the shared FPU pair (adder + multiplier, start/done handshakes, common a/b operand bus). It sits directly upstream of the FPU system. It fetches weight/input pairs from synchronous ROM/RAM ports and issues multiply then accumulate-add operations. It returns the 32-bit sum to the gate controller with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 32, float word width
- VEC_LEN, 16, maximum vector length
- ADDR_WIDTH, $clog2(VEC_LEN), element address width
- TIMEOUT_CYCLES, 64, FPU done watchdog limit (used only with the macro below)

- clk  in  1  rising-edge clock
- rstn  in  1  synchronous, active-high reset (1 = reset)
- start  in  1  begin a dot product; sampled only in IDLE
- n_elems  in  ADDR_WIDTH+1  element count 0..VEC_LEN, latched on start
- bias  in  DATA_WIDTH  initial accumulator value, latched on start
- elem_addr  out  ADDR_WIDTH  shared read address for weight and input memories
- w_data / x_data  in  DATA_WIDTH  read data, valid one cycle after elem_addr
- fpu_a / fpu_b  out  DATA_WIDTH  shared FPU operand bus
- mult_start / add_start  out  1  one-cycle FPU start pulses
- mult_done / add_done  in  1  FPU completion
- mult_out / add_out  in  DATA_WIDTH  FPU results, valid while the matching done is high
- busy  out  1  high from start acceptance until the done cycle
- done  out  1  one-cycle completion pulse
- result  out  DATA_WIDTH  final sum, held until the next done
- err  out  1  watchdog abort pulse (0 without the macro)

## Operation
- IDLE: when start=1, latch n_elems and bias; set acc←bias, idx←0, busy←1. Next state is FETCH if n>0, else FINISH. start is ignored in all other states.
- FETCH: drive elem_addr=idx. Next state WAIT_RD.
- WAIT_RD: register w_data→op_w and x_data→op_x. Next state MUL.
- MUL: mult_start=1, fpu_a=op_w, fpu_b=op_x. Next state MUL_WAIT.
- MUL_WAIT: hold operands. On mult_done, set prod←mult_out. Next state ADD.
- ADD: add_start=1, fpu_a=acc, fpu_b=prod. Next state ADD_WAIT.
- ADD_WAIT: on add_done, set acc←add_out. If idx==n−1, next state FINISH; otherwise idx←idx+1 and next state FETCH.
- FINISH: result←acc, done=1, busy←0. Next state IDLE.
- n_elems>VEC_LEN saturates to VEC_LEN.
- The sequencer performs no float arithmetic itself; all rounding comes from the FPU.
- A done from the FPU that the current state is not waiting for is ignored.
- Reset (any state): return to IDLE. Outputs reset to busy=0, done=0, err=0, result=0, fpu_a=fpu_b=0, start pulses 0, elem_addr=0. An in-flight FPU operation is abandoned.

## Timing
- Start accepted at cycle 0. FINISH/done occurs at cycle 1 + n·(4 + Lm + La).
  - Lm = cycles spent in MUL_WAIT, including the mult_done cycle (≥1).
  - La = the same for ADD_WAIT.
- n=0: done at cycle 1, result=bias.
- FPU start pulses are exactly one cycle. Operands stay stable from the start cycle through the matching done cycle.
- done and err are never high together. start high during the done cycle is not accepted; the sequencer is back in IDLE one cycle later.

## Configuration
- GRU_DOT_SEQ_TIMEOUT_EN defined: a counter runs in MUL_WAIT and ADD_WAIT and clears on state entry. After TIMEOUT_CYCLES cycles without done:
  - pulse err for one cycle;
  - clear busy and return to IDLE;
  - leave result unchanged and do not pulse done.
- Not defined: no counter; the sequencer waits indefinitely and err is tied 0.

## Structure
- Shared package gru_fpu_pkg holds:
  - the state enum;
  - float constants FP_ZERO=0x00000000 and FP_ONE=0x3F800000;
  - the DATA_WIDTH default.
- One optional sub-module, gru_dot_watchdog (counter plus compare). It is instantiated only under GRU_DOT_SEQ_TIMEOUT_EN.

## Test plan
- VEC_LEN=4, n=4, w=1.0 (0x3F800000), x=2.0 (0x40000000), bias=0.5 (0x3F000000), FPU stubs Lm=La=3 → result 0x41080000 (8.5). done at cycle 1+4·10=41; exactly 4 mult_start and 4 add_start pulses.
- n=0, bias=3.0 (0x40400000) → done at cycle 1, result 0x40400000, no FPU starts, no elem_addr activity.
- start re-asserted while busy, with different bias → ignored; first result correct; no second done.
- rstn asserted in MUL_WAIT → next cycle IDLE with all outputs at reset values. A new start then completes correctly.
- Stray add_done during MUL_WAIT → ignored; sum still correct.
- With GRU_DOT_SEQ_TIMEOUT_EN and mult_done tied 0 → err pulse at TIMEOUT_CYCLES after MUL_WAIT entry, busy=0, no done, result unchanged.
